// File: rtl/seq_mul_unit.sv
// Iterative 32x32 shift-add multiplier for the RV32M MUL group.
// One shared ripple-carry adder step per cycle; 34-cycle round trip.
module seq_mul_fa1 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module seq_mul_add32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_ci,
  output logic [31:0] o_sum,
  output logic        o_co
);
  logic [32:0] c;

  assign c[0] = i_ci;
  assign o_co = c[32];

  for (genvar g = 0; g < 32; g++) begin : g_fa
    seq_mul_fa1 u_fa (
      .i_a  (i_a[g]),
      .i_b  (i_b[g]),
      .i_ci (c[g]),
      .o_s  (o_sum[g]),
      .o_co (c[g+1])
    );
  end
endmodule

module seq_mul_unit #(
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [1:0]       i_op,
  input  logic [31:0]      i_rs1,
  input  logic [31:0]      i_rs2,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_busy,
  output logic             o_valid,
  output logic [31:0]      o_result,
  output logic [TAG_W-1:0] o_tag
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_HSU  = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      mcand_q, mcand_d;
  logic [31:0]      mplr_q, mplr_d;
  logic [31:0]      acc_hi_q, acc_hi_d;
  logic             neg_q, neg_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [31:0]      res_q, res_d;
  logic [TAG_W-1:0] otag_q, otag_d;

  logic        rs1_sgn, rs2_sgn;
  logic        rs1_neg, rs2_neg;
  logic [31:0] rs1_mag, rs2_mag;
  logic [31:0] add_b, add_sum;
  logic        add_co;
  logic [63:0] prod, prod_fix;

  assign rs1_sgn = (i_op == OP_MULH) || (i_op == OP_HSU);
  assign rs2_sgn = (i_op == OP_MULH);
  assign rs1_neg = rs1_sgn & i_rs1[31];
  assign rs2_neg = rs2_sgn & i_rs2[31];
  // |0x80000000| stays 0x80000000 when read as unsigned
  assign rs1_mag = rs1_neg ? (~i_rs1 + 32'd1) : i_rs1;
  assign rs2_mag = rs2_neg ? (~i_rs2 + 32'd1) : i_rs2;

  assign add_b = mplr_q[0] ? mcand_q : 32'd0;

  seq_mul_add32 u_add (
    .i_a   (acc_hi_q),
    .i_b   (add_b),
    .i_ci  (1'b0),
    .o_sum (add_sum),
    .o_co  (add_co)
  );

  assign prod     = {acc_hi_q, mplr_q};
  assign prod_fix = neg_q ? (~prod + 64'd1) : prod;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tag_d    = tag_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_hi_d = acc_hi_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    otag_d   = otag_q;

    case (state_q)
      S_IDLE: begin
        if (i_start && !i_flush) begin
          op_d     = i_op;
          tag_d    = i_tag;
          mcand_d  = rs1_mag;
          mplr_d   = rs2_mag;
          neg_d    = rs1_neg ^ rs2_neg;
          acc_hi_d = 32'd0;
          cnt_d    = 5'd0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_hi_d = {add_co, add_sum[31:1]};
        mplr_d   = {add_sum[0], mplr_q[31:1]};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (!i_flush) begin
          res_d  = (op_q == OP_MUL) ? prod_fix[31:0]
                                    : prod_fix[63:32];
          otag_d = tag_q;
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (i_flush) state_d = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 2'd0;
      tag_q    <= '0;
      mcand_q  <= 32'd0;
      mplr_q   <= 32'd0;
      acc_hi_q <= 32'd0;
      neg_q    <= 1'b0;
      cnt_q    <= 5'd0;
      res_q    <= 32'd0;
      otag_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_hi_q <= acc_hi_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      otag_q   <= otag_d;
    end
  end

  assign o_busy   = (state_q != S_IDLE);
  assign o_valid  = (state_q == S_DONE);
  assign o_result = res_q;
  assign o_tag    = otag_q;
endmodule
